// File: rtl/bank_accounter_if.sv
// Write-snoop and read-select bus between the bank array side and the live-value table.
interface bank_accounter_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int NB_WRAGENT   = 2,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT)
);
    logic [NB_WRAGENT-1:0]              m_wren;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0]   m_wraddr;
    logic [NB_RDAGENT-1:0]              m_rden;
    logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr;
    logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect;
    logic [NB_RDAGENT-1:0]              rdvalid;

    modport master (
        output m_wren, m_wraddr, m_rden, m_rdaddr,
        input  rdselect, rdvalid
    );

    modport slave (
        input  m_wren, m_wraddr, m_rden, m_rdaddr,
        output rdselect, rdvalid
    );
endinterface

// File: rtl/bank_accounter.sv
// Live-value table: remembers which write bank holds the latest data per address
// and steers each read agent to that bank in the same cycle as its request.
module bank_accounter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int NB_WRAGENT   = 2,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                clear,
    bank_accounter_if.slave     bus,
    output logic                wrcollision,
    output logic [15:0]         collision_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0]        r_valid;
    logic [SELECT_WIDTH-1:0] r_bank [DEPTH];

    logic [NB_RDAGENT*SELECT_WIDTH-1:0] w_rdselect;
    logic [NB_RDAGENT-1:0]              w_rdvalid_nxt;
    logic [NB_RDAGENT-1:0]              r_rdvalid;
    logic                               w_detect;
    logic                               r_wrcollision;
    logic [15:0]                        r_collision_cnt;

    // Later agents overwrite earlier ones in the loop, so the highest index wins a tie.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid <= '0;
            for (int a = 0; a < DEPTH; a++) begin
                r_bank[a] <= '0;
            end
        end else if (clear) begin
            r_valid <= '0;
            for (int a = 0; a < DEPTH; a++) begin
                r_bank[a] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (bus.m_wren[i]) begin
                    r_valid[bus.m_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
                    r_bank[bus.m_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]]  <= SELECT_WIDTH'(i);
                end
            end
        end
    end

    // Read lookup sees pre-edge state, matching the bank's own read-during-write behaviour.
    always_comb begin
        w_rdselect    = '0;
        w_rdvalid_nxt = '0;
        for (int r = 0; r < NB_RDAGENT; r++) begin
            w_rdselect[r*SELECT_WIDTH +: SELECT_WIDTH] =
                r_bank[bus.m_rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            w_rdvalid_nxt[r] = bus.m_rden[r] &
                r_valid[bus.m_rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

    always_comb begin
        w_detect = 1'b0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            for (int j = i + 1; j < NB_WRAGENT; j++) begin
                if (bus.m_wren[i] && bus.m_wren[j] &&
                    (bus.m_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                     bus.m_wraddr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    w_detect = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rdvalid <= '0;
        end else begin
            r_rdvalid <= w_rdvalid_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wrcollision   <= 1'b0;
            r_collision_cnt <= '0;
        end else if (clear) begin
            r_wrcollision   <= 1'b0;
            r_collision_cnt <= '0;
        end else begin
            r_wrcollision <= w_detect;
            if (w_detect && (r_collision_cnt != 16'hFFFF)) begin
                r_collision_cnt <= r_collision_cnt + 16'd1;
            end
        end
    end

    assign bus.rdselect  = w_rdselect;
    assign bus.rdvalid   = r_rdvalid;
    assign wrcollision   = r_wrcollision;
    assign collision_cnt = r_collision_cnt;

endmodule

// File: tb/tb_bank_accounter.sv
// Directed vector bench for bank_accounter: table of per-cycle stimulus plus
// hand-written saturation and asynchronous-reset sequences.
module tb_bank_accounter;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        clear = 1'b0;
    logic        wrcollision;
    logic [15:0] collision_cnt;

    int checks = 0;
    int failures = 0;

    bank_accounter_if #(.ADDR_WIDTH(8), .NB_WRAGENT(2), .NB_RDAGENT(2)) bus ();

    bank_accounter #(.ADDR_WIDTH(8), .NB_WRAGENT(2), .NB_RDAGENT(2)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .clear         (clear),
        .bus           (bus),
        .wrcollision   (wrcollision),
        .collision_cnt (collision_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        clr;
        logic [1:0]  wren;
        logic [7:0]  wa0;
        logic [7:0]  wa1;
        logic [1:0]  rden;
        logic [7:0]  ra0;
        logic [7:0]  ra1;
        logic [1:0]  e_sel;   // rdselect during this cycle
        logic [1:0]  e_vld;   // rdvalid after the edge
        logic        e_coll;  // wrcollision after the edge
        logic [15:0] e_cnt;   // collision_cnt after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic [1:0] wren, logic [7:0] wa0, logic [7:0] wa1,
                                logic [1:0] rden, logic [7:0] ra0, logic [7:0] ra1,
                                logic [1:0] e_sel, logic [1:0] e_vld, logic e_coll,
                                logic [15:0] e_cnt);
        vec_t v;
        v.clr = clr; v.wren = wren; v.wa0 = wa0; v.wa1 = wa1;
        v.rden = rden; v.ra0 = ra0; v.ra1 = ra1;
        v.e_sel = e_sel; v.e_vld = e_vld; v.e_coll = e_coll; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic [1:0] wren, input logic [7:0] wa0,
                         input logic [7:0] wa1, input logic [1:0] rden,
                         input logic [7:0] ra0, input logic [7:0] ra1);
        clear        = clr;
        bus.m_wren   = wren;
        bus.m_wraddr = {wa1, wa0};
        bus.m_rden   = rden;
        bus.m_rdaddr = {ra1, ra0};
    endtask

    initial begin
        drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);

        //            clr wren  wa0    wa1    rden  ra0    ra1    sel    vld    coll cnt
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 8'h10, 8'hFF, 2'b00, 2'b00, 0, 16'd0));
        vecs.push_back(mk(0, 2'b10, 8'h00, 8'h20, 2'b00, 8'h10, 8'hFF, 2'b00, 2'b00, 0, 16'd0));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b01, 8'h20, 8'h00, 2'b01, 2'b01, 0, 16'd0));
        vecs.push_back(mk(0, 2'b01, 8'h20, 8'h00, 2'b00, 8'h20, 8'h00, 2'b01, 2'b00, 0, 16'd0));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b01, 8'h20, 8'h00, 2'b00, 2'b01, 0, 16'd0));
        vecs.push_back(mk(0, 2'b10, 8'h00, 8'h30, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 16'd0));
        vecs.push_back(mk(0, 2'b01, 8'h30, 8'h00, 2'b10, 8'h00, 8'h30, 2'b10, 2'b10, 0, 16'd0));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b10, 8'h00, 8'h30, 2'b00, 2'b10, 0, 16'd0));
        vecs.push_back(mk(0, 2'b11, 8'h40, 8'h40, 2'b00, 8'h40, 8'h40, 2'b00, 2'b00, 1, 16'd1));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 8'h40, 8'h40, 2'b11, 2'b11, 0, 16'd1));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h41, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 16'd2));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h41, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 16'd3));
        vecs.push_back(mk(0, 2'b11, 8'h41, 8'h41, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 16'd4));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 16'd4));
        vecs.push_back(mk(0, 2'b11, 8'h60, 8'h61, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 16'd4));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 8'h60, 8'h61, 2'b10, 2'b11, 0, 16'd4));
        vecs.push_back(mk(1, 2'b10, 8'h00, 8'h50, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 16'd0));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 8'h50, 8'h61, 2'b00, 2'b00, 0, 16'd0));
        vecs.push_back(mk(0, 2'b11, 8'h70, 8'h70, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 16'd1));
        vecs.push_back(mk(1, 2'b11, 8'h70, 8'h70, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 16'd0));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 8'h70, 8'h70, 2'b00, 2'b00, 0, 16'd0));

        // Reset state
        #3;
        check("rst_rdselect", 32'(bus.rdselect), 32'h0);
        check("rst_rdvalid", 32'(bus.rdvalid), 32'h0);
        check("rst_wrcollision", 32'(wrcollision), 32'h0);
        check("rst_collision_cnt", 32'(collision_cnt), 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge aclk);
            drive(vecs[k].clr, vecs[k].wren, vecs[k].wa0, vecs[k].wa1,
                  vecs[k].rden, vecs[k].ra0, vecs[k].ra1);
            #1;
            check($sformatf("v%0d_rdselect", k), 32'(bus.rdselect), 32'(vecs[k].e_sel));
            @(posedge aclk);
            #1;
            check($sformatf("v%0d_rdvalid", k), 32'(bus.rdvalid), 32'(vecs[k].e_vld));
            check($sformatf("v%0d_wrcollision", k), 32'(wrcollision), 32'(vecs[k].e_coll));
            check($sformatf("v%0d_collision_cnt", k), 32'(collision_cnt), 32'(vecs[k].e_cnt));
        end

        // Saturation: 65540 consecutive collision cycles on address 0x01
        @(negedge aclk);
        drive(1'b0, 2'b11, 8'h01, 8'h01, 2'b11, 8'h01, 8'h01);
        repeat (65540) @(posedge aclk);
        #1;
        check("sat_collision_cnt", 32'(collision_cnt), 32'hFFFF);
        check("sat_wrcollision", 32'(wrcollision), 32'h1);
        check("sat_rdselect", 32'(bus.rdselect), 32'h3);
        check("sat_rdvalid", 32'(bus.rdvalid), 32'h3);

        // Asynchronous reset asserted mid-cycle
        @(negedge aclk);
        drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b11, 8'h01, 8'h40);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_rdselect", 32'(bus.rdselect), 32'h0);
        check("arst_rdvalid", 32'(bus.rdvalid), 32'h0);
        check("arst_wrcollision", 32'(wrcollision), 32'h0);
        check("arst_collision_cnt", 32'(collision_cnt), 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("post_arst_rdvalid", 32'(bus.rdvalid), 32'h0);
        check("post_arst_rdselect", 32'(bus.rdselect), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bank_accounter.md
# bank_accounter

Live-value table for the banked multi-port RAM. It records, per address, which write-agent bank holds the most recent data. It also supplies each read agent's bank selector to the read switch, so a read returns the latest write regardless of which agent wrote it. The block sits beside the bank array: it snoops all write agents and feeds `rdselect` to the read-side switch in the same cycle as the read request.

## Interface

Parameters:
- ADDR_WIDTH, 8: write/read address width; the table has 2^ADDR_WIDTH entries.
- NB_WRAGENT, 2: number of write agents, which equals the number of banks.
- NB_RDAGENT, 2: number of read agents.
- SELECT_WIDTH, (NB_WRAGENT==1 ? 1 : $clog2(NB_WRAGENT)): bank index width.

Ports:
- aclk  in  1  single clock, all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous table clear, active high.
- m_wren  in  NB_WRAGENT  write enable per write agent.
- m_wraddr  in  NB_WRAGENT*ADDR_WIDTH  write address per agent; slice i is agent i.
- m_rden  in  NB_RDAGENT  read enable per read agent.
- m_rdaddr  in  NB_RDAGENT*ADDR_WIDTH  read address per agent.
- rdselect  out  NB_RDAGENT*SELECT_WIDTH  bank index per read agent; combinational from m_rdaddr.
- rdvalid  out  NB_RDAGENT  registered; entry read last cycle had been written since reset/clear.
- wrcollision  out  1  registered pulse; two or more agents wrote the same address last cycle.
- collision_cnt  out  16  saturating count of collision cycles.

## Operation

- Table entry = {valid, bank[SELECT_WIDTH-1:0]}, held in flops. Async reset and `clear` set every entry to {0, 0}.
- Write: for each agent i with m_wren[i]=1, entry[m_wraddr[i]] <= {1, i} at the next edge.
- Same-address writes in one cycle: the highest agent index wins. This is consistent with the bank array, where every bank is written and only the recorded one is read back.
- Read: rdselect slice r = bank field of entry[m_rdaddr[r]], independent of m_rden. Unwritten entries read 0.
- rdvalid[r] <= m_rden[r] & valid field of entry[m_rdaddr[r]]. It is 0 when m_rden[r]=0.
- Collision detect: any pair i<j with both enabled and equal addresses. wrcollision <= detect. collision_cnt increments on detect and saturates at 0xFFFF.
- `clear` has priority over writes in the same cycle. It also zeroes collision_cnt and wrcollision.
- No back-pressure and no handshake: every enabled write is accepted every cycle.

## Timing

- Reset values: table all {0,0}; rdselect = 0 when all entries are cleared; rdvalid = 0; wrcollision = 0; collision_cnt = 0.
- rdselect has zero-cycle latency. It reflects table state at the start of the cycle and is used by the read switch in the same cycle as m_rden. The read switch registers it to match the bank's FFDed output.
- Read-during-write, same address, same cycle: rdselect returns the old bank. The bank also returns old data, so the read is coherent and no bypass is needed.
- A write at edge N is visible on rdselect from cycle N+1.
- rdvalid and wrcollision have 1-cycle latency relative to their inputs.
- aresetn asserted mid-operation clears all state immediately. Writes in flight are lost.

## Test plan

- Reset then read: read addr 0x10 and 0xFF with m_rden=11. Required: rdselect=0 for both; rdvalid=00 next cycle; all outputs 0.
- Basic tracking: agent 1 writes 0x20, then agent 0 reads 0x20. Required: rdselect slice 0 = 1 and rdvalid[0]=1. Then agent 0 writes 0x20, and a read the following cycle gives rdselect=0.
- Read-during-write: agent 0 writes 0x30 (prior owner agent 1) while agent 1 reads 0x30 in the same cycle. Required: rdselect=1 that cycle and 0 the next cycle.
- Collision: both agents write 0x40 in one cycle. Required: entry owner=1, wrcollision=1 for exactly one cycle, collision_cnt=1. Repeat 3 more times and collision_cnt=4.
- Clear vs write: clear=1 together with agent 1 writing 0x50. Required: read 0x50 gives rdselect=0, rdvalid=0, collision_cnt=0.
- Saturation and async reset: force 65540 collision cycles. Required: collision_cnt stays at 0xFFFF. Then pulse aresetn low mid-cycle, and all outputs/table must be 0 before the next edge.
